// File: rtl/uart_rx_operand_ctrl_if.sv
// Bus between the UART bit receiver / RSA core side and the operand controller.
// Carries the serial bit strobe, end-of-transmission level, core handshake and operand load port.
interface uart_rx_operand_ctrl_if #(
  parameter int WIDTH = 32
);
  // Strobe semantics: bit_ready, op_load, start, core_done and err are single-cycle
  // qualifiers with no backpressure; the payload (bit_in, op_data/op_sel, err_code) is
  // valid only in the cycle its strobe is high, and every strobe must be consumed or flagged.
  logic             bit_ready;
  logic             bit_in;
  logic             eot;
  logic             core_done;
  logic [WIDTH-1:0] op_data;
  logic [1:0]       op_sel;
  logic             op_load;
  logic             start;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output bit_ready, bit_in, eot, core_done,
    input  op_data, op_sel, op_load, start, busy, err, err_code
  );

  modport slave (
    input  bit_ready, bit_in, eot, core_done,
    output op_data, op_sel, op_load, start, busy, err, err_code
  );
endinterface

// File: rtl/uart_rx_operand_ctrl.sv
// Assembles LSB-first serial bits into NUM_OPS operands, loads them into the RSA
// operand slots, fires start on end-of-transmission and flags malformed frames.
module uart_rx_operand_ctrl #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_operand_ctrl_if.slave bus,
  output logic [2:0]            dbg_state
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [1:0]      LAST_SLOT = 2'(NUM_OPS - 1);
  localparam logic [1:0]      ERR_SHORT = 2'b01;
  localparam logic [1:0]      ERR_LONG  = 2'b10;
  localparam logic [1:0]      ERR_BUSY  = 2'b11;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    LOAD    = 3'd1,
    ARMED   = 3'd2,
    START   = 3'd3,
    RUN     = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sr_q, sr_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [1:0]       slot_q, slot_n;
  logic [WIDTH-1:0] op_data_q, op_data_n;
  logic             busy_q, busy_n;
  logic             err_q, err_n;
  logic [1:0]       err_code_q, err_code_n;
  logic             eot_q;
  logic             start_pend_q, start_pend_n;
  logic             short_pend_q, short_pend_n;

  logic             eot_rise;
  logic             bit_done;
  logic             last_slot;
  logic [WIDTH-1:0] shift_word;

  assign eot_rise   = bus.eot & ~eot_q;
  assign shift_word = {bus.bit_in, sr_q[WIDTH-1:1]};
  assign bit_done   = bus.bit_ready && (cnt_q == LAST_BIT);
  assign last_slot  = (slot_q == LAST_SLOT);

  always_comb begin
    state_n      = state_q;
    sr_n         = sr_q;
    cnt_n        = cnt_q;
    slot_n       = slot_q;
    op_data_n    = op_data_q;
    busy_n       = busy_q;
    start_pend_n = start_pend_q;
    short_pend_n = short_pend_q;
    err_n        = 1'b0;
    err_code_n   = 2'b00;

    case (state_q)
      COLLECT: begin
        if (bus.bit_ready) begin
          sr_n  = shift_word;
          cnt_n = cnt_q + 1'b1;
        end
        if (bit_done) begin
          op_data_n = shift_word;
          cnt_n     = '0;
          state_n   = LOAD;
          // An eot landing on a completing bit is resolved once the load is done.
          if (eot_rise) begin
            if (last_slot) start_pend_n = 1'b1;
            else           short_pend_n = 1'b1;
          end
        end else if (eot_rise) begin
          err_n      = 1'b1;
          err_code_n = ERR_SHORT;
          cnt_n      = '0;
          slot_n     = '0;
        end
      end

      LOAD: begin
        start_pend_n = 1'b0;
        short_pend_n = 1'b0;
        if (!last_slot) begin
          state_n = COLLECT;
          if (short_pend_q || eot_rise) begin
            err_n      = 1'b1;
            err_code_n = ERR_SHORT;
            cnt_n      = '0;
            slot_n     = '0;
          end else begin
            slot_n = slot_q + 2'd1;
            if (bus.bit_ready) begin
              sr_n  = shift_word;
              cnt_n = cnt_q + 1'b1;
            end
          end
        end else begin
          slot_n = '0;
          if (bus.bit_ready) begin
            err_n      = 1'b1;
            err_code_n = ERR_LONG;
            // If the frame's eot has already been seen there is nothing left to drain.
            state_n    = (start_pend_q || eot_rise) ? COLLECT : DRAIN;
          end else if (start_pend_q || eot_rise) begin
            state_n = START;
          end else begin
            state_n = ARMED;
          end
        end
      end

      ARMED: begin
        if (bus.bit_ready) begin
          err_n      = 1'b1;
          err_code_n = ERR_LONG;
          state_n    = eot_rise ? COLLECT : DRAIN;
        end else if (eot_rise) begin
          state_n = START;
        end
      end

      START: begin
        busy_n  = 1'b1;
        state_n = RUN;
        if (bus.bit_ready) begin
          err_n      = 1'b1;
          err_code_n = ERR_BUSY;
        end
      end

      RUN: begin
        if (bus.bit_ready) begin
          err_n      = 1'b1;
          err_code_n = ERR_BUSY;
        end
        if (bus.core_done) begin
          busy_n  = 1'b0;
          cnt_n   = '0;
          slot_n  = '0;
          state_n = COLLECT;
        end
      end

      DRAIN: begin
        if (eot_rise) begin
          cnt_n   = '0;
          slot_n  = '0;
          state_n = COLLECT;
        end
      end

      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      sr_q         <= '0;
      cnt_q        <= '0;
      slot_q       <= '0;
      op_data_q    <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      eot_q        <= 1'b0;
      start_pend_q <= 1'b0;
      short_pend_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      sr_q         <= sr_n;
      cnt_q        <= cnt_n;
      slot_q       <= slot_n;
      op_data_q    <= op_data_n;
      busy_q       <= busy_n;
      err_q        <= err_n;
      err_code_q   <= err_code_n;
      eot_q        <= bus.eot;
      start_pend_q <= start_pend_n;
      short_pend_q <= short_pend_n;
    end
  end

  assign bus.op_data  = op_data_q;
  assign bus.op_sel   = slot_q;
  assign bus.op_load  = (state_q == LOAD);
  assign bus.start    = (state_q == START);
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign dbg_state    = state_q;

  a_load_start_excl: assert property (@(posedge clk) disable iff (rst) !(bus.op_load && bus.start));
  a_err_has_code:    assert property (@(posedge clk) disable iff (rst) bus.err |-> (bus.err_code != 2'b00));
  a_start_then_busy: assert property (@(posedge clk) disable iff (rst) bus.start |=> bus.busy);

endmodule

// File: doc/uart_rx_operand_ctrl.md
Name: uart_rx_operand_ctrl

Overview:
- Sequences the UART bit-level receiver into the RSA datapath.
- Collects the serial bit stream (bit_ready/bit_in) into WIDTH-bit operands and loads them, in order, into NUM_OPS operand slots (slot 0 = message, 1 = exponent, 2 = modulus).
- On end-of-transmission with all slots loaded, pulses start to the RSA core and holds off further input until the core reports done.
- Detects and reports short frames, long frames and data that arrives while the core is busy.

Parameters:
- WIDTH, 32: operand width in bits; must be ≥ 2.
- NUM_OPS, 3: number of operand slots per frame; 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bit_ready  in  1  one-clk strobe: bit_in is valid this cycle
- bit_in  in  1  received bit; operands are sent LSB first
- eot  in  1  end-of-transmission level from the receiver; may stay high for many cycles
- core_done  in  1  one-clk strobe from the RSA core: computation finished
- op_data  out  WIDTH  assembled operand; stable while op_load is high
- op_sel  out  2  destination slot index for op_data
- op_load  out  1  one-clk strobe: write op_data into slot op_sel
- start  out  1  one-clk strobe to the RSA core
- busy  out  1  high from start until core_done
- err  out  1  one-clk error strobe
- err_code  out  2  01 short frame, 10 long frame, 11 data while busy; valid when err = 1

Behaviour:
- Reset (rst high at a clk edge): state COLLECT; shift register, bit count, slot index, op_data, op_sel cleared; op_load, start, busy, err, err_code all 0; eot_q = 0.
- eot edge: eot_q <= eot every cycle; eot_rise = eot & ~eot_q. Only eot_rise acts; a long eot level triggers once.
- Bit assembly (states COLLECT and LOAD only):
  - On bit_ready: sr <= {bit_in, sr[WIDTH-1:1]} and cnt <= cnt + 1.
  - cnt is $clog2(WIDTH+1) bits wide.
  - When bit_ready makes cnt reach WIDTH: op_data <= {bit_in, sr[WIDTH-1:1]}, cnt <= 0, go to LOAD.
- States:
  - COLLECT: accumulate bits.
    - eot_rise with no bit completing the last slot: err = 1, err_code = 01, then clear cnt and slot, stay in COLLECT.
    - If the final bit of slot NUM_OPS-1 and eot_rise occur in the same cycle, the frame counts as complete: go to LOAD, and LOAD moves to START instead of ARMED.
  - LOAD (1 cycle):
    - op_load = 1, op_sel = slot.
    - Next: slot < NUM_OPS-1 → slot++, COLLECT. Otherwise slot <= 0 and go to ARMED, or to START if the eot_rise was pending.
    - A bit_ready arriving during LOAD is accepted into the next operand. If the last slot was just loaded, that bit counts as a long-frame error as in ARMED.
    - An eot_rise during LOAD that is not for the final slot is a short-frame error, applied after the load completes.
  - ARMED: all slots loaded, waiting for eot.
    - eot_rise → START.
    - bit_ready → err = 1, err_code = 10, go to DRAIN.
  - START (1 cycle): start = 1, busy <= 1, then RUN.
  - RUN: busy = 1.
    - bit_ready → err = 1, err_code = 11 (pulse only); the bit is discarded.
    - core_done → busy <= 0, COLLECT with cnt and slot = 0.
    - eot_rise is ignored.
  - DRAIN: ignore bits; eot_rise → COLLECT with cnt and slot = 0. No further errors are raised.
- Latency:
  - op_load is high the cycle after the completing bit_ready.
  - start is high 1 cycle after the eot_rise seen in ARMED, or 2 cycles after the completing bit when it coincides with eot_rise.
  - busy falls the cycle after core_done.
- At most one err strobe per cycle. Error precedence: 11 over 10 over 01.
- core_done outside RUN is ignored.
- Reset mid-frame discards all partial data. No op_load or start is issued after reset until a full new frame arrives.

Test Plan:
- WIDTH=8, NUM_OPS=3: send bytes 0xA5, 0x03, 0x37 LSB first, then eot.
  - Required: three op_load pulses with op_sel 0/1/2 and op_data A5/03/37, then one start 1 cycle after eot_rise, busy high until core_done, and a return to COLLECT.
- Send 0xA5 plus 4 bits, then eot.
  - Required: one op_load (A5), err = 1 with err_code = 01, no start. A following full frame loads and starts normally.
- Full frame plus one extra bit before eot.
  - Required: err_code = 10 on the extra bit, no start.
  - eot returns the block to COLLECT; the next full frame then starts normally.
- During RUN, inject 3 bit_ready strobes.
  - Required: three err pulses with err_code = 11, no op_load, busy stays high.
  - core_done clears busy; a new frame then works.
- Last bit of slot 2 coincident with eot_rise.
  - Required: op_load (op_sel = 2) on the next cycle, start on the cycle after that.
- eot held high for 50 cycles, and rst asserted mid-operand.
  - Required: only one eot action. After reset, all outputs are 0 and the next frame starts at slot 0 with an empty shift register.
